muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_muldiv_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, with MTHI/MTLO writes, flush abort and async reset.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [1:0]       state_dbg
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

   state_t             state, state_nx;
   logic [CW-1:0]      cnt;
   logic               is_div, neg_q, neg_r, div_zero;
   logic [WIDTH-1:0]   reg_a, reg_b, reg_u, a_orig;
   logic               accept_md, mt_hi, mt_lo, commit, last_iter, sgn;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     add_sum, div_shift, div_trial;
   logic [2*WIDTH-1:0] prod_u, prod_s;
   logic [WIDTH-1:0]   quo_s, rem_s, res_hi, res_lo;

   assign state_dbg = state;

   // Handshake: start is a request sampled only in IDLE; it is accepted on the
   // rising edge where state is IDLE, start=1 and flush=0. There is no ready:
   // requests outside IDLE are dropped, and done pulses once per HI/LO update.
   always_comb begin
      state_nx  = state;
      accept_md = 1'b0;
      mt_hi     = 1'b0;
      mt_lo     = 1'b0;
      commit    = 1'b0;
      last_iter = (cnt == CW'(WIDTH - 1));
      case (state)
         IDLE: begin
            if (start && !flush) begin
               if (!op[2]) begin
                  accept_md = 1'b1;
                  state_nx  = RUN;
               end else if (op[1:0] == 2'b00) begin
                  mt_hi = 1'b1;
               end else if (op[1:0] == 2'b01) begin
                  mt_lo = 1'b1;
               end
            end
         end
         RUN: begin
            if (flush)          state_nx = IDLE;
            else if (last_iter) state_nx = FIN;
         end
         FIN: begin
            commit   = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Signed ops run on magnitudes; signs are reapplied at commit.
   always_comb begin
      sgn       = ~op[0];
      mag_a     = (sgn && a[WIDTH-1]) ? -a : a;
      mag_b     = (sgn && b[WIDTH-1]) ? -b : b;
      add_sum   = {1'b0, reg_u} + (reg_a[0] ? {1'b0, reg_b} : '0);
      div_shift = {reg_u, reg_a[WIDTH-1]};
      div_trial = div_shift - {1'b0, reg_b};
      prod_u    = {reg_u, reg_a};
      prod_s    = neg_q ? -prod_u : prod_u;
      quo_s     = neg_q ? -reg_a : reg_a;
      rem_s     = neg_r ? -reg_u : reg_u;
      if (!is_div) begin
         {res_hi, res_lo} = prod_s;
      end else if (div_zero) begin
         res_hi = a_orig;
         res_lo = '1;
      end else begin
         res_hi = rem_s;
         res_lo = quo_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         reg_a    <= '0;
         reg_b    <= '0;
         reg_u    <= '0;
         a_orig   <= '0;
      end else if (accept_md) begin
         cnt      <= '0;
         is_div   <= op[1];
         neg_q    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
         neg_r    <= sgn & a[WIDTH-1];
         div_zero <= (b == '0);
         reg_a    <= mag_a;
         reg_b    <= mag_b;
         reg_u    <= '0;
         a_orig   <= a;
      end else if (state == RUN) begin
         cnt <= cnt + 1'b1;
         if (!is_div) begin
            // reg_u:reg_a is the product, reg_a doubling as the multiplier shifter
            reg_u <= add_sum[WIDTH:1];
            reg_a <= {add_sum[0], reg_a[WIDTH-1:1]};
         end else if (!div_trial[WIDTH]) begin
            reg_u <= div_trial[WIDTH-1:0];
            reg_a <= {reg_a[WIDTH-2:0], 1'b1};
         end else begin
            reg_u <= div_shift[WIDTH-1:0];
            reg_a <= {reg_a[WIDTH-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
         hi   <= '0;
         lo   <= '0;
      end else begin
         busy <= (state_nx == RUN);
         done <= commit | mt_hi | mt_lo;
         if (commit) begin
            hi <= res_hi;
            lo <= res_lo;
         end else begin
            if (mt_hi) hi <= a;
            if (mt_lo) lo <= a;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: randomized and directed operations, a reference model
// in plain arithmetic, and a scoreboard popped by a done-driven monitor.
module tb_muldiv_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, start, flush;
   logic [2:0]   op;
   logic [W-1:0] a, b, hi, lo;
   logic         busy, done;
   logic [1:0]   state_dbg;

   logic [2*W-1:0] exp_q[$];
   logic [2*W-1:0] mon_e;
   logic [W-1:0]   m_hi = '0, m_lo = '0;
   int             n_checks = 0, n_errors = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo),
      .state_dbg(state_dbg)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: HI/LO contents after a multiply/divide on x, y.
   function automatic logic [63:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      int     sx, sy, q, m;
      longint p;
      logic [63:0] r;
      sx = x;
      sy = y;
      r  = '0;
      case (o)
         3'd0: begin
            p = longint'(sx) * longint'(sy);
            r = p;
         end
         3'd1: r = {32'b0, x} * {32'b0, y};
         3'd2: begin
            if (y == 0) r = {x, 32'hFFFF_FFFF};
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
            else begin
               q = sx / sy;
               m = sx % sy;
               r = {32'(m), 32'(q)};
            end
         end
         3'd3: begin
            if (y == 0) r = {x, 32'hFFFF_FFFF};
            else r = {x % y, x / y};
         end
         default: r = {m_hi, m_lo};
      endcase
      return r;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Monitor: every done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done: got done=1 hi=%h lo=%h expected no done", hi, lo);
         end else begin
            mon_e = exp_q.pop_front();
            check("result", {hi, lo}, mon_e);
         end
      end
   end

   task automatic run_md(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit flush_fin);
      logic [63:0]  e;
      logic [W-1:0] hi0, lo0;
      int           busy_n, done_n, done_at;
      @(negedge clk);
      hi0   = m_hi;
      lo0   = m_lo;
      start = 1'b1; op = o; a = x; b = y;
      e = model(o, x, y);
      exp_q.push_back(e);
      {m_hi, m_lo} = e;
      @(posedge clk);
      #1;
      start = 1'b0; a = $urandom; b = $urandom;
      busy_n = 0; done_n = 0; done_at = 0;
      for (int c = 1; c <= W + 4; c++) begin
         @(negedge clk);
         flush = flush_fin && (c == W + 1);
         start = (c == 5) || (c == W + 1);
         if (start) begin
            op = 3'($urandom_range(0, 5));
            a  = $urandom;
            b  = $urandom;
         end
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            if (done_at == 0) done_at = c;
         end
         if (c == W / 2) check("hold_mid_run", {hi, lo}, {hi0, lo0});
      end
      flush = 1'b0;
      start = 1'b0;
      check("busy_cycles", busy_n, W);
      check("done_latency", done_at, W + 2);
      check("done_pulses", done_n, 1);
   endtask

   task automatic run_mt(input logic [2:0] o, input logic [W-1:0] x);
      @(negedge clk);
      start = 1'b1; op = o; a = x; flush = 1'b0;
      if (o == 3'd4) m_hi = x;
      else           m_lo = x;
      exp_q.push_back({m_hi, m_lo});
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("mt_done", done, 1);
      check("mt_busy", busy, 0);
   endtask

   task automatic run_reject(input logic [2:0] o, input bit fl);
      @(negedge clk);
      start = 1'b1; op = o; a = $urandom; b = $urandom; flush = fl;
      @(posedge clk);
      #1;
      start = 1'b0; flush = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("reject_done", done, 0);
         check("reject_busy", busy, 0);
      end
      check("reject_hilo", {hi, lo}, {m_hi, m_lo});
   endtask

   task automatic run_flush_mid();
      int done_n;
      @(negedge clk);
      start = 1'b1; op = 3'd0; a = $urandom; b = $urandom;
      @(posedge clk);
      #1;
      start = 1'b0;
      done_n = 0;
      for (int c = 1; c <= W + 6; c++) begin
         @(negedge clk);
         start = (c == 5);
         if (start) begin
            op = 3'd1;
            a  = $urandom;
            b  = $urandom;
         end
         flush = (c == 10);
         if (done) done_n++;
         if (c == 12) check("flush_busy", busy, 0);
         if (c == 8)  check("flush_busy_before", busy, 1);
      end
      start = 1'b0;
      flush = 1'b0;
      check("flush_no_done", done_n, 0);
      check("flush_hilo", {hi, lo}, {m_hi, m_lo});
   endtask

   task automatic run_reset_mid_div();
      int done_n;
      @(negedge clk);
      start = 1'b1; op = 3'd2; a = $urandom | 32'h1; b = $urandom | 32'h1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_hilo", {hi, lo}, 64'h0);
      m_hi = '0;
      m_lo = '0;
      @(negedge clk);
      rst = 1'b0;
      done_n = 0;
      for (int c = 0; c < W + 6; c++) begin
         @(negedge clk);
         if (done) done_n++;
      end
      check("rst_no_done", done_n, 0);
      check("rst_hilo_after", {hi, lo}, 64'h0);
   endtask

   initial begin
      logic [2:0]   o;
      logic [W-1:0] x, y;
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_hi", hi, 0);
      check("reset_lo", lo, 0);
      rst = 1'b0;

      run_md(3'd0, 32'hFFFF_FFFF, 32'h2, 1'b0);
      check("mult_vec", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
      run_md(3'd1, 32'hFFFF_FFFF, 32'h2, 1'b0);
      check("multu_vec", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
      run_md(3'd2, 32'hFFFF_FFF9, 32'h2, 1'b0);
      check("div_neg_vec", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check("div_ovf_vec", {hi, lo}, 64'h0000_0000_8000_0000);
      run_md(3'd3, 32'h7, 32'h0, 1'b0);
      check("divu_zero_vec", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
      run_md(3'd2, 32'hFFFF_FF00, 32'h0, 1'b0);
      run_md(3'd2, 32'h0000_0011, 32'hFFFF_FFFB, 1'b0);

      run_mt(3'd5, 32'h1234_5678);
      check("mtlo_vec", lo, 32'h1234_5678);
      run_mt(3'd4, 32'hCAFE_F00D);
      run_flush_mid();
      run_md(3'd0, 32'h8000_0000, 32'h8000_0000, 1'b1);
      run_reject(3'd6, 1'b0);
      run_reject(3'd7, 1'b0);
      run_reject(3'd4, 1'b1);
      run_reject(3'd5, 1'b1);
      run_reject(3'd0, 1'b1);

      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(0, 5));
         x = pick();
         y = pick();
         if (o < 3'd4) run_md(o, x, y, $urandom_range(0, 7) == 0);
         else          run_mt(o, x);
      end

      run_reset_mid_div();
      run_md(3'd3, 32'd1000, 32'd7, 1'b0);
      check("divu_after_rst", {hi, lo}, {32'd6, 32'd142});

      repeat (3) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not reach its end within the time limit");
      $fatal(1);
   end

endmodule
